// File: rtl/clarvi_regfile_pkg.sv
// Shared types and helpers for the slice-serial Clarvi register file.
package clarvi_regfile_pkg;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RUN  = 1'b1
    } seq_state_t;

    typedef enum logic [0:0] {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } seq_dir_t;

    // Widest register the mask helper can describe; callers truncate to XLEN.
    localparam int unsigned MaxXlen = 256;

    // Ones over slice 'part' of a register built from slices of 'slice_w' bits.
    function automatic logic [MaxXlen-1:0] slice_mask(input int unsigned part,
                                                      input int unsigned slice_w);
        logic [MaxXlen-1:0] ones;
        ones = '0;
        for (int unsigned i = 0; i < MaxXlen; i++) begin
            if (i < slice_w) ones[i] = 1'b1;
        end
        return ones << (part * slice_w);
    endfunction

endpackage

// File: rtl/clarvi_slice_counter.sv
// Slice sequencer: owns the current slice index, the walk direction, hold
// handling and detection of the final slice of a sequence.
module clarvi_slice_counter
    import clarvi_regfile_pkg::*;
#(
    parameter int unsigned NSLICES = 8,
    parameter int unsigned PW      = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          load_i,
    input  seq_dir_t      dir_i,
    input  logic          run_i,
    input  logic          hold_i,
    output logic [PW-1:0] part_o,
    output logic          last_o
);

    localparam logic [PW-1:0] TopPart = PW'(NSLICES - 1);

    seq_dir_t      dir_q, dir_d;
    logic [PW-1:0] part_q, part_d;

    assign part_o = part_q;
    assign last_o = run_i && (part_q == ((dir_q == DIR_DOWN) ? '0 : TopPart));

    // Load start slice on accept, otherwise step unless held; park at 0 when done.
    always_comb begin
        dir_d  = dir_q;
        part_d = part_q;
        if (load_i) begin
            dir_d  = dir_i;
            part_d = (dir_i == DIR_DOWN) ? TopPart : '0;
        end else if (run_i && !hold_i) begin
            if (last_o) begin
                part_d = '0;
            end else if (dir_q == DIR_DOWN) begin
                part_d = part_q - PW'(1);
            end else begin
                part_d = part_q + PW'(1);
            end
        end
    end

    // Counter state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            dir_q  <= DIR_UP;
            part_q <= '0;
        end else begin
            dir_q  <= dir_d;
            part_q <= part_d;
        end
    end

endmodule

// File: rtl/clarvi_seq_regfile.sv
// Slice-serial integer register file for the bit-serial Clarvi datapath.
// A start handshake latches rs1/rs2/rd; the sequencer then presents one slice
// per cycle and optionally writes one slice of rd. x0 reads as zero.
// Optional feature: define CLARVI_REGFILE_DEBUG_EN to expose debug_reg.
module clarvi_seq_regfile
    import clarvi_regfile_pkg::*;
#(
    parameter int unsigned XLEN      = 64,
    parameter int unsigned SLICE_W   = 8,
    parameter int unsigned NREGS     = 32,
    parameter int unsigned DEBUG_REG = 28,
    localparam int unsigned NSLICES  = XLEN / SLICE_W,
    localparam int unsigned RW       = $clog2(NREGS),
    localparam int unsigned PW       = (NSLICES > 1) ? $clog2(NSLICES) : 1
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start_valid,
    output logic               start_ready,
    input  logic               start_dir,
    input  logic [RW-1:0]      rs1,
    input  logic [RW-1:0]      rs2,
    input  logic [RW-1:0]      rd,
    input  logic               hold,
    input  logic               wr_slice_en,
    input  logic [SLICE_W-1:0] data_in,
    output logic [SLICE_W-1:0] data_out_1,
    output logic [SLICE_W-1:0] data_out_2,
    output logic               slice_valid,
    output logic [PW-1:0]      slice_part,
    output logic               slice_last
`ifdef CLARVI_REGFILE_DEBUG_EN
    ,
    output logic [XLEN-1:0]    debug_reg
`endif
);

    seq_state_t    state_q, state_d;
    logic [RW-1:0] rs1_q, rs1_d;
    logic [RW-1:0] rs2_q, rs2_d;
    logic [RW-1:0] rd_q, rd_d;

    logic          run;
    logic          accept;
    logic          seq_end;
    logic          last;
    logic [PW-1:0] part;

    logic [XLEN-1:0]  regs_q [NREGS];
    logic             wr_en;
    logic [XLEN-1:0]  wr_word_d;
    logic [XLEN-1:0]  mask;
    int unsigned      shamt;

    assign run     = (state_q == RUN);
    assign seq_end = run && last && !hold;

    clarvi_slice_counter #(
        .NSLICES (NSLICES),
        .PW      (PW)
    ) u_slice_counter (
        .clock  (clock),
        .reset  (reset),
        .load_i (accept),
        .dir_i  (seq_dir_t'(start_dir)),
        .run_i  (run),
        .hold_i (hold),
        .part_o (part),
        .last_o (last)
    );

    // Handshake and next-state: accept from IDLE or back-to-back on the last slice.
    always_comb begin
        start_ready = !reset && (!run || seq_end);
        accept      = start_valid && start_ready;
        state_d     = state_q;
        rs1_d       = rs1_q;
        rs2_d       = rs2_q;
        rd_d        = rd_q;
        if (accept) begin
            state_d = RUN;
            rs1_d   = rs1;
            rs2_d   = rs2;
            rd_d    = rd;
        end else if (seq_end) begin
            state_d = IDLE;
        end
    end

    // Sequencer state and latched indices.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            rs1_q   <= '0;
            rs2_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            rd_q    <= rd_d;
        end
    end

    // Read-modify-write word for the current slice of rd; reset cancels the write.
    always_comb begin
        shamt     = 32'(part) * SLICE_W;
        mask      = XLEN'(slice_mask(32'(part), SLICE_W));
        wr_en     = run && wr_slice_en && (rd_q != '0) && !reset;
        wr_word_d = (regs_q[rd_q] & ~mask) | ((XLEN'(data_in) << shamt) & mask);
    end

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (wr_en) begin
            regs_q[rd_q] <= wr_word_d;
        end
    end

    // Slice outputs come from the stored array only, so data_in never reaches them.
    always_comb begin
        slice_valid = run;
        slice_last  = last;
        slice_part  = part;
        data_out_1  = (run && rs1_q != '0) ? SLICE_W'(regs_q[rs1_q] >> shamt) : '0;
        data_out_2  = (run && rs2_q != '0) ? SLICE_W'(regs_q[rs2_q] >> shamt) : '0;
    end

`ifdef CLARVI_REGFILE_DEBUG_EN
    // Debug mirror of one architectural register.
    always_comb begin
        debug_reg = (DEBUG_REG == 0) ? '0 : regs_q[DEBUG_REG];
    end
`endif

endmodule

// File: tb/tb_clarvi_seq_regfile.sv
// Scoreboard bench for clarvi_seq_regfile: a driver walks each sequence from
// the register-file rules and queues the expected slices; a negedge monitor
// pops and compares whatever the DUT presents.
module tb_clarvi_seq_regfile;

    localparam int NREGS = 32;
    localparam int NSL   = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_valid;
    logic       start_ready;
    logic       start_dir;
    logic [4:0] rs1, rs2, rd;
    logic       hold;
    logic       wr_slice_en;
    logic [7:0] data_in;
    logic [7:0] data_out_1, data_out_2;
    logic       slice_valid;
    logic [2:0] slice_part;
    logic       slice_last;
`ifdef CLARVI_REGFILE_DEBUG_EN
    logic [63:0] debug_reg;
`endif

    clarvi_seq_regfile dut (
        .clock       (clock),
        .reset       (reset),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .start_dir   (start_dir),
        .rs1         (rs1),
        .rs2         (rs2),
        .rd          (rd),
        .hold        (hold),
        .wr_slice_en (wr_slice_en),
        .data_in     (data_in),
        .data_out_1  (data_out_1),
        .data_out_2  (data_out_2),
        .slice_valid (slice_valid),
        .slice_part  (slice_part),
        .slice_last  (slice_last)
`ifdef CLARVI_REGFILE_DEBUG_EN
        ,
        .debug_reg   (debug_reg)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        int         part;
        logic [7:0] d1;
        logic [7:0] d2;
        bit         last;
    } exp_t;

    typedef struct {
        logic [4:0]  rs1, rs2, rd;
        bit          dir;
        int          wr_pct;
        int          hold_pct;
        int          hold_at;
        bit          chain;
        bit          rst_at4;
        logic [63:0] wdata;
    } seq_t;

    exp_t        expq[$];
    seq_t        seqs[$];
    logic [63:0] mdl[NREGS];
    int          n_checks = 0;
    int          n_fail   = 0;
    bit          mon_en   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [7:0] mslice(input logic [4:0] r, input int p);
        logic [63:0] w;
        if (r == 0) return 8'h00;
        w = mdl[r];
        return w[p*8 +: 8];
    endfunction

    function automatic seq_t mk(input logic [4:0] a, input logic [4:0] b, input logic [4:0] d,
                                input bit dir, input int wr_pct, input bit chain,
                                input logic [63:0] wdata);
        seq_t s;
        s.rs1 = a; s.rs2 = b; s.rd = d; s.dir = dir; s.wr_pct = wr_pct;
        s.hold_pct = 0; s.hold_at = -1; s.chain = chain; s.rst_at4 = 0; s.wdata = wdata;
        return s;
    endfunction

    task automatic set_idx(input seq_t s);
        rs1 = s.rs1; rs2 = s.rs2; rd = s.rd; start_dir = s.dir;
    endtask

    // Monitor: every negedge, DUT slice_valid must agree with the scoreboard.
    always @(negedge clock) begin
        exp_t e;
        if (mon_en) begin
            check("slice_valid", slice_valid, expq.size() > 0);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                if (slice_valid) begin
                    check("slice_part", slice_part, e.part);
                    check("data_out_1", data_out_1, e.d1);
                    check("data_out_2", data_out_2, e.d2);
                    check("slice_last", slice_last, e.last);
                end
            end else begin
                check("idle_outputs", {slice_last, slice_part, data_out_1, data_out_2}, 0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        seq_t s;
        int k, p, hold_cnt;
        bit h, we, in_run;
        logic [7:0] din;
        exp_t e;

        reset = 1; start_valid = 0; start_dir = 0; rs1 = 0; rs2 = 0; rd = 0;
        hold = 0; wr_slice_en = 0; data_in = 0;
        mdl[0] = '0;

        // Give every register a known value first (reads of x0 only).
        for (int r = 1; r < NREGS; r++)
            seqs.push_back(mk(0, 0, 5'(r), $urandom_range(1), 100, 1, {$urandom, $urandom}));
        seqs[NREGS-2].chain = 0;
        seqs.push_back(mk(0, 0, 5, 0, 100, 0, 64'h8877665544332211));
        seqs.push_back(mk(5, 3, 0, 0, 0, 0, 0));
        seqs.push_back(mk(5, 3, 0, 1, 0, 0, 0));
        seqs.push_back(mk(0, 5, 0, 0, 100, 0, 64'hFFFF_FFFF_FFFF_FFFF));
        seqs.push_back(mk(0, 0, 0, 0, 0, 0, 0));
        s = mk(9, 9, 9, 0, 100, 1, {$urandom, $urandom}); s.hold_at = 2;
        seqs.push_back(s);
        seqs.push_back(mk(9, 5, 0, 0, 0, 0, 0));
        seqs.push_back(mk(0, 0, 7, 0, 100, 0, 64'h0));
        s = mk(7, 0, 7, 0, 100, 0, 64'hA1B2C3D4E5F60718); s.rst_at4 = 1;
        seqs.push_back(s);
        seqs.push_back(mk(7, 7, 0, 0, 0, 0, 0));
        for (int n = 0; n < 40; n++) begin
            s = mk(5'($urandom), 5'($urandom), 5'($urandom), $urandom_range(1),
                   ($urandom_range(2)) * 50, $urandom_range(1), {$urandom, $urandom});
            s.hold_pct = 25;
            seqs.push_back(s);
        end
        seqs[seqs.size()-1].chain = 0;

        @(posedge clock); #1;
        mon_en = 1;
        #1 check("ready_in_reset_start", start_ready, 0);
        @(posedge clock); #1;
        reset = 0;
        #1 check("ready_after_init", start_ready, 1);

        in_run = 0;
        for (int i = 0; i < seqs.size(); i++) begin
            s = seqs[i];
            if (!in_run) begin
                @(posedge clock); #1;
                hold = 1'($urandom); wr_slice_en = 1'($urandom); data_in = 8'($urandom);
                start_valid = 1; set_idx(s);
                #1 check("ready_idle", start_ready, 1);
            end
            in_run = 0;
            k = 0; hold_cnt = 0;
            while (k < NSL) begin
                @(posedge clock); #1;
                start_valid = 0;
                p = s.dir ? NSL - 1 - k : k;
                if (s.hold_at == k) h = (hold_cnt < 2);
                else h = ($urandom_range(99) < s.hold_pct);
                if (h && s.hold_at == k) hold_cnt++;
                we  = ($urandom_range(99) < s.wr_pct);
                din = we ? s.wdata[p*8 +: 8] : 8'($urandom);
                hold = h; wr_slice_en = we; data_in = din;
                e.part = p; e.d1 = mslice(s.rs1, p); e.d2 = mslice(s.rs2, p);
                e.last = (k == NSL - 1);
                expq.push_back(e);
                if (s.rst_at4 && k == 4) begin
                    reset = 1;
                    #1 check("ready_during_reset", start_ready, 0);
                    @(posedge clock); #1;
                    reset = 0; wr_slice_en = 0; hold = 0;
                    #1 check("ready_after_reset", start_ready, 1);
                    break;
                end
                if (we && s.rd != 0) mdl[s.rd][p*8 +: 8] = din;
                if (k == NSL - 1 && s.chain && i + 1 < seqs.size()) begin
                    start_valid = 1; set_idx(seqs[i+1]);
                    #1 check("ready_last", start_ready, !h);
                    if (!h) in_run = 1;
                end
                if (!h) k++;
            end
        end

        @(posedge clock); #1;
        start_valid = 0; wr_slice_en = 0; hold = 0;
        repeat (3) @(posedge clock);
        #1 check("queue_drained", expq.size(), 0);
`ifdef CLARVI_REGFILE_DEBUG_EN
        check("debug_reg", debug_reg, mdl[28]);
`endif
        mon_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/clarvi_seq_regfile.md
# clarvi_seq_regfile

Parametrised, slice-serial integer register file for the bit-serial Clarvi datapath. A start handshake latches two source indices and one destination, and an internal sequencer then walks every slice of the registers, one slice per cycle, in ascending or descending order. On each step it presents the two source slices and optionally writes one destination slice. Register x0 reads as zero and ignores writes. The block sits between decode and the serial ALU.

## Interface
- XLEN, 64: register width in bits.
- SLICE_W, 8: slice width; must divide XLEN; NSLICES = XLEN/SLICE_W.
- NREGS, 32: number of registers; index width RW = $clog2(NREGS).
- DEBUG_REG, 28: register index mirrored to the debug port.

Ports:
- clock  in  1  sole clock; everything on posedge.
- reset  in  1  synchronous, active-high.
- start_valid  in  1  request a sequence.
- start_ready  out  1  sequence can be accepted this cycle.
- start_dir  in  1  0 = slice 0 first (LSB), 1 = slice NSLICES-1 first (MSB).
- rs1, rs2  in  RW  source indices, latched on accept.
- rd  in  RW  destination index, latched on accept.
- hold  in  1  freeze the slice counter this cycle.
- wr_slice_en  in  1  write data_in into the current slice of the latched rd.
- data_in  in  SLICE_W  write data.
- data_out_1, data_out_2  out  SLICE_W  current slice of rs1 / rs2.
- slice_valid  out  1  a slice is being presented.
- slice_part  out  $clog2(NSLICES)  index of the current slice.
- slice_last  out  1  final slice of the sequence.
- debug_reg  out  XLEN  registers[DEBUG_REG] (present only under the macro below).

## Operation
- States: IDLE, RUN.
- Accept occurs when start_valid && start_ready.
- start_ready = (state==IDLE) || (state==RUN && slice_last && !hold). Ready is 0 while reset is asserted.
- Accept from IDLE, or back-to-back from the last RUN cycle:
  - next state RUN;
  - rs1, rs2, rd and dir are latched;
  - part = 0 if dir==0, else NSLICES-1.
- In RUN with hold==0: part steps +1 (dir 0) or -1 (dir 1).
- slice_last = RUN && part==(dir ? 0 : NSLICES-1).
- On a slice_last cycle with hold==0 and no accept, the next state is IDLE.
- In RUN with hold==1: part, state and latched indices are unchanged, and outputs are stable.
- Read path:
  - data_out_n = registers[rs_n][part*SLICE_W +: SLICE_W], combinational from the latched index and part;
  - a latched index of 0 gives 0.
- Write path: if RUN && wr_slice_en && rd!=0, the current slice of registers[rd] takes data_in at the clock edge.
  - The write happens regardless of hold.
  - All other slices of rd are preserved.
- Read-during-write of the same slice, with rs==rd: data_out shows the old value. The new value is visible from the next cycle.
- In IDLE: wr_slice_en is ignored; data_out_1/2, slice_valid and slice_last are 0; slice_part is 0.

## Timing
- Reset values: state IDLE, part 0, latched indices 0, start_ready 0 during the reset cycle, slice_valid/slice_last 0, data_out 0.
- Register contents are not reset. Reset in mid-sequence abandons the sequence, and slices already written keep their new values.
- Start-to-first-slice latency is 1 cycle.
- A sequence occupies NSLICES + (cycles with hold high) cycles.
- Back-to-back sequences have zero idle cycles.
- No combinational path from data_in to any output.

## Configuration
- CLARVI_REGFILE_DEBUG_EN:
  - defined: debug_reg port exists and is driven combinationally with registers[DEBUG_REG] (0 if DEBUG_REG==0);
  - undefined: the port and its logic are absent.

## Structure
- Package clarvi_regfile_pkg holds:
  - seq_state_t enum (IDLE, RUN);
  - seq_dir_t enum (DIR_UP, DIR_DOWN);
  - function slice_mask(part) used for read-modify-write.
- One sub-module, clarvi_slice_counter, owns part, the step direction, hold and slice_last generation.
- Storage and the state machine stay in the top level.

## Test plan
- Write x5 ascending with data_in 0x11,0x22,…,0x88, then read rs1=5 ascending → 0x11…0x88, slice_part 0…7, slice_last on the 8th; registers[5]=0x8877665544332211.
- Read x5 descending → first slice 0x88 with slice_part 7, slice_last with 0x11 at part 0.
- Sequence with rd=0 writing 0xFF in all slices, rs1=0 → data_out_1 always 0; a following read of x0 returns 0.
- hold high for 2 cycles at part 2 → part and outputs frozen; sequence lasts 10 cycles. A write under hold lands in slice 2 only.
- start_valid held high across sequences → second start accepted on the slice_last cycle; next cycle RUN at part 0 with new indices, no IDLE gap.
- Reset at part 4 of a write to x7 (prior value 0) → IDLE next cycle with ready=1; x7 slices 0–3 hold the new data and slices 4–7 stay 0.
